// File: rtl/vga_scan_timing_if.sv
// Pixel-request bus between the VGA scan generator (master) and the pixel source (slave).
interface vga_scan_timing_if;
  logic [23:0] rgb_in;
  logic [9:0]  req_x;
  logic [9:0]  req_y;
  logic        req_valid;

  modport master (input rgb_in, output req_x, output req_y, output req_valid);
  modport slave  (output rgb_in, input req_x, input req_y, input req_valid);
endinterface

// File: rtl/vga_scan_timing.sv
// 640x480@60 VGA raster generator on CLOCK_50 with a divide-by-2 pixel tick.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN.
module vga_scan_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET_N,
  vga_scan_timing_if.master         pix,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                      pattern_sel,
`endif
  output logic                      frame_start,
  output logic [7:0]                VGA_R,
  output logic [7:0]                VGA_G,
  output logic [7:0]                VGA_B,
  output logic                      VGA_HS,
  output logic                      VGA_VS,
  output logic                      VGA_BLANK_N,
  output logic                      VGA_SYNC_N,
  output logic                      VGA_CLK
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic        pix_en;
  logic [9:0]  h;
  logic [9:0]  v;
  logic [9:0]  h_nxt;
  logic [9:0]  v_nxt;
  logic        line_end;
  logic        frame_end;
  logic        in_active;
  logic        nxt_active;
  logic        in_hsync;
  logic        in_vsync;
  logic [23:0] pix_rgb;
  logic [23:0] out_rgb;
  logic        req_valid_q;

`ifdef VGA_TEST_PATTERN_EN
  function automatic logic [23:0] bar_colour(input logic [9:0] x);
    logic [23:0] c;
    if      (x < 10'd80)  c = 24'hFFFFFF;
    else if (x < 10'd160) c = 24'hFFFF00;
    else if (x < 10'd240) c = 24'h00FFFF;
    else if (x < 10'd320) c = 24'h00FF00;
    else if (x < 10'd400) c = 24'hFF00FF;
    else if (x < 10'd480) c = 24'hFF0000;
    else if (x < 10'd560) c = 24'h0000FF;
    else                  c = 24'h000000;
    return c;
  endfunction
`endif

  always_comb begin
    line_end  = (h == H_LAST);
    frame_end = line_end && (v == V_LAST);
    h_nxt     = h;
    v_nxt     = v;
    if (pix_en) begin
      if (line_end) begin
        h_nxt = '0;
        v_nxt = (v == V_LAST) ? '0 : v + 10'd1;
      end else begin
        h_nxt = h + 10'd1;
      end
    end
    in_active  = (h < H_ACT) && (v < V_ACT);
    nxt_active = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    in_hsync   = (h >= HS_BEGIN) && (h < HS_END);
    in_vsync   = (v >= VS_BEGIN) && (v < VS_END);
  end

  always_comb begin
    pix_rgb = pix.rgb_in;
`ifdef VGA_TEST_PATTERN_EN
    if (pattern_sel) pix_rgb = bar_colour(h);
`endif
  end

  // req_valid is registered so it reads 0 straight out of reset even though (0,0) is active;
  // the output stage decodes the active area from h/v directly.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      pix_en      <= 1'b0;
      VGA_CLK     <= 1'b0;
      h           <= '0;
      v           <= '0;
      req_valid_q <= 1'b0;
      frame_start <= 1'b0;
      out_rgb     <= '0;
      VGA_BLANK_N <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
    end else begin
      pix_en      <= ~pix_en;
      VGA_CLK     <= pix_en;
      h           <= h_nxt;
      v           <= v_nxt;
      req_valid_q <= nxt_active;
      frame_start <= pix_en && frame_end;
      if (pix_en) begin
        out_rgb     <= in_active ? pix_rgb : '0;
        VGA_BLANK_N <= in_active;
        VGA_HS      <= ~in_hsync;
        VGA_VS      <= ~in_vsync;
      end
    end
  end

  assign pix.req_x     = h;
  assign pix.req_y     = v;
  assign pix.req_valid = req_valid_q;
  assign VGA_R         = out_rgb[23:16];
  assign VGA_G         = out_rgb[15:8];
  assign VGA_B         = out_rgb[7:0];
  assign VGA_SYNC_N    = 1'b0;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Directed bench for vga_scan_timing: full-size instance for line timing, shrunk instance for frame timing.
module tb_vga_scan_timing;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_scan_timing_if big_if();
  vga_scan_timing_if sml_if();

  logic       big_fs, sml_fs;
  logic [7:0] big_r, big_g, big_b, sml_r, sml_g, sml_b;
  logic       big_hs, big_vs, big_blank, big_sync, big_clk;
  logic       sml_hs, sml_vs, sml_blank, sml_sync, sml_clk;
`ifdef VGA_TEST_PATTERN_EN
  logic       big_psel = 1'b0;
  logic       sml_psel = 1'b0;
`endif

  vga_scan_timing dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .pix(big_if),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(big_psel),
`endif
    .frame_start(big_fs), .VGA_R(big_r), .VGA_G(big_g), .VGA_B(big_b),
    .VGA_HS(big_hs), .VGA_VS(big_vs), .VGA_BLANK_N(big_blank),
    .VGA_SYNC_N(big_sync), .VGA_CLK(big_clk)
  );

  // H_TOTAL=15 (hsync h=10..12), V_TOTAL=11 (vsync v=7..8): one frame = 330 CLOCK_50 cycles.
  vga_scan_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_s (
    .CLOCK_50(clk), .RESET_N(rst_n), .pix(sml_if),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(sml_psel),
`endif
    .frame_start(sml_fs), .VGA_R(sml_r), .VGA_G(sml_g), .VGA_B(sml_b),
    .VGA_HS(sml_hs), .VGA_VS(sml_vs), .VGA_BLANK_N(sml_blank),
    .VGA_SYNC_N(sml_sync), .VGA_CLK(sml_clk)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned edges = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edges);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (4) step();
    rst_n = 1'b1;
    edges = 0;
  endtask

  typedef struct {
    int unsigned edge_n;
    logic [23:0] rgb;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        valid;
    logic [23:0] out;
    logic        blank;
    logic        hs;
    logic        vclk;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned blank_cnt, bad_rgb, hs_low, hs_first, clk_bad, big_fs_cnt;
    int unsigned fs_cnt, fs_first, fs_second, s_blank, s_bad, vs_low, vs_first;
    int unsigned p;

    big_if.rgb_in = 24'h123456;
    sml_if.rgb_in = 24'hFFFFFF;

    //            edge   rgb_in        x    y  val out          blk hs clk
    vecs[0]  = '{0,    24'h123456, 0,   0, 0, 24'h000000, 0, 1, 0};
    vecs[1]  = '{1,    24'h123456, 0,   0, 1, 24'h000000, 0, 1, 0};
    vecs[2]  = '{2,    24'h123456, 1,   0, 1, 24'h123456, 1, 1, 1};
    vecs[3]  = '{3,    24'h123456, 1,   0, 1, 24'h123456, 1, 1, 0};
    vecs[4]  = '{4,    24'h123456, 2,   0, 1, 24'h123456, 1, 1, 1};
    vecs[5]  = '{1280, 24'h123456, 640, 0, 0, 24'h123456, 1, 1, 1};
    vecs[6]  = '{1282, 24'h123456, 641, 0, 0, 24'h000000, 0, 1, 1};
    vecs[7]  = '{1314, 24'h123456, 657, 0, 0, 24'h000000, 0, 0, 1};
    vecs[8]  = '{1400, 24'hFFFFFF, 700, 0, 0, 24'h000000, 0, 0, 1};
    vecs[9]  = '{1504, 24'h123456, 752, 0, 0, 24'h000000, 0, 0, 1};
    vecs[10] = '{1506, 24'h123456, 753, 0, 0, 24'h000000, 0, 1, 1};
    vecs[11] = '{1600, 24'h123456, 0,   1, 1, 24'h000000, 0, 1, 1};
    vecs[12] = '{1602, 24'h123456, 1,   1, 1, 24'h123456, 1, 1, 1};

    // Phase 1: reset values and probe points along line 0.
    do_reset();
    check("sync_n", {31'd0, big_sync}, 32'd0);
    check("reset_vs", {31'd0, big_vs}, 32'd1);
    check("reset_fs", {31'd0, big_fs}, 32'd0);
    for (int i = 0; i < 13; i++) begin
      big_if.rgb_in = vecs[i].rgb;
      while (edges < vecs[i].edge_n) step();
      check($sformatf("v%0d_req_x", i),     {22'd0, big_if.req_x},     {22'd0, vecs[i].x});
      check($sformatf("v%0d_req_y", i),     {22'd0, big_if.req_y},     {22'd0, vecs[i].y});
      check($sformatf("v%0d_req_valid", i), {31'd0, big_if.req_valid}, {31'd0, vecs[i].valid});
      check($sformatf("v%0d_rgb", i),       {8'd0, big_r, big_g, big_b}, {8'd0, vecs[i].out});
      check($sformatf("v%0d_blank_n", i),   {31'd0, big_blank},        {31'd0, vecs[i].blank});
      check($sformatf("v%0d_hs", i),        {31'd0, big_hs},           {31'd0, vecs[i].hs});
      check($sformatf("v%0d_vga_clk", i),   {31'd0, big_clk},          {31'd0, vecs[i].vclk});
    end

    // Phase 2: free-run one full line (big) and two small frames.
    big_if.rgb_in = 24'h123456;
    sml_if.rgb_in = 24'hFFFFFF;
    do_reset();
    blank_cnt = 0; bad_rgb = 0; hs_low = 0; hs_first = 9999; clk_bad = 0; big_fs_cnt = 0;
    fs_cnt = 0; fs_first = 0; fs_second = 0; s_blank = 0; s_bad = 0; vs_low = 0; vs_first = 9999;
    for (int e = 1; e <= 1600; e++) begin
      step();
      if (big_clk !== ((edges % 2) == 0)) clk_bad++;
      if (big_fs) big_fs_cnt++;
      if ((edges % 2) == 0) begin
        p = edges / 2 - 1;
        if (big_blank) blank_cnt++;
        if (big_blank ? ({big_r, big_g, big_b} !== 24'h123456) : ({big_r, big_g, big_b} !== 24'h0)) bad_rgb++;
        if (!big_hs) begin
          hs_low++;
          if (hs_first == 9999) hs_first = p;
        end
      end
      if (edges <= 700 && sml_fs) begin
        fs_cnt++;
        if (fs_cnt == 1) fs_first = edges;
        if (fs_cnt == 2) fs_second = edges;
      end
      if (edges >= 2 && edges <= 331) begin
        if (sml_blank) s_blank++;
        if (sml_blank ? ({sml_r, sml_g, sml_b} !== 24'hFFFFFF) : ({sml_r, sml_g, sml_b} !== 24'h0)) s_bad++;
        if (!sml_vs) begin
          vs_low++;
          if (vs_first == 9999) vs_first = edges;
        end
      end
    end
    check("line_blank_ticks", blank_cnt, 640);
    check("line_rgb_errors", bad_rgb, 0);
    check("line_hs_low_ticks", hs_low, 96);
    check("line_hs_first_pixel", hs_first, 656);
    check("line_vga_clk_errors", clk_bad, 0);
    check("line_period_x", {22'd0, big_if.req_x}, 0);
    check("line_period_y", {22'd0, big_if.req_y}, 1);
    check("big_no_frame_start", big_fs_cnt, 0);
    check("frame_start_count", fs_cnt, 2);
    check("frame_start_first", fs_first, 330);
    check("frame_start_second", fs_second, 660);
    check("sml_blank_cycles", s_blank, 96);
    check("sml_rgb_errors", s_bad, 0);
    check("vs_low_cycles", vs_low, 60);
    check("vs_first_edge", vs_first, 212);

    // Phase 3: one-cycle reset in the middle of a small-frame line during hsync.
    do_reset();
    while (edges < 112) step();
    check("mid_pre_x", {22'd0, sml_if.req_x}, 11);
    check("mid_pre_y", {22'd0, sml_if.req_y}, 3);
    check("mid_pre_hs", {31'd0, sml_hs}, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    edges = 0;
    check("mid_x", {22'd0, sml_if.req_x}, 0);
    check("mid_y", {22'd0, sml_if.req_y}, 0);
    check("mid_hs", {31'd0, sml_hs}, 1);
    check("mid_blank_n", {31'd0, sml_blank}, 0);
    check("mid_req_valid", {31'd0, sml_if.req_valid}, 0);
    check("mid_vga_clk", {31'd0, sml_clk}, 0);
    check("mid_frame_start", {31'd0, sml_fs}, 0);
    check("mid_big_x", {22'd0, big_if.req_x}, 0);
    fs_cnt = 0;
    for (int e = 0; e < 40; e++) begin
      step();
      if (sml_fs || big_fs) fs_cnt++;
    end
    check("post_reset_no_fs", fs_cnt, 0);
    check("post_reset_x", {22'd0, sml_if.req_x}, 5);
    check("post_reset_y", {22'd0, sml_if.req_y}, 1);

`ifdef VGA_TEST_PATTERN_EN
    // Phase 4: colour bars on line 10; pixel (x,10) appears after edge 2*(8000+x+1).
    begin
      int unsigned px[5];
      logic [23:0] pc[5];
      px = '{0, 79, 80, 400, 639};
      pc = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFF0000, 24'h000000};
      big_if.rgb_in = 24'h123456;
      big_psel = 1'b1;
      do_reset();
      for (int i = 0; i < 5; i++) begin
        while (edges < 2 * (8000 + px[i] + 1)) step();
        check($sformatf("bar_x%0d_rgb", px[i]), {8'd0, big_r, big_g, big_b}, {8'd0, pc[i]});
        check($sformatf("bar_x%0d_blank_n", px[i]), {31'd0, big_blank}, 32'd1);
      end
      big_psel = 1'b0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
